// File: rtl/dot_product_pkg.sv
// Shared types and constants for the MLP dot-product reference designs.
package dot_product_pkg;

  localparam int MLP_INT_W = 8;
  localparam int MLP_PAR   = 4;
  localparam int SUM_W     = 48;
  localparam int RESULT_W  = 16;

  typedef struct packed {
    logic                last;
    logic                sat;
    logic [RESULT_W-1:0] data;
  } dp_result_t;

  // Shifting by the full sum width or more would discard the sign, so cap at sum_w-1.
  function automatic logic [5:0] clamp_shift(input logic [5:0] shift, input int unsigned sum_w);
    int unsigned sh;
    sh = {26'd0, shift};
    if (sh > sum_w - 1) return 6'(sum_w - 1);
    return shift;
  endfunction

endpackage

// File: rtl/dot_product_result_fifo.sv
// Synchronous first-word-fall-through FIFO of dp_result_t; the head stays visible while not empty.
module dot_product_result_fifo
  import dot_product_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  dp_result_t i_wdata,
  input  logic       i_pop,
  output dp_result_t o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  dp_result_t mem_q [DEPTH];
  dp_result_t hold_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        wr_en, rd_en;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = i_pop && !o_empty;
  // When full, a write is still legal if the head slot is freed in the same cycle.
  assign wr_en   = i_push && (!o_full || rd_en);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        hold_q   <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  // An empty FIFO keeps showing the last popped entry rather than a stale slot.
  assign o_rdata = o_empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/dot_product_result_quant.sv
// Rounds, shifts and saturates finished dot-product sums, then streams them with batch framing.
module dot_product_result_quant
  import dot_product_pkg::*;
#(
  parameter int S     = SUM_W,
  parameter int OUT_W = RESULT_W,
  parameter int DEPTH = 8,
  parameter int BATCH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [S-1:0]     i_sum,
  input  logic             i_valid,
  input  logic [5:0]       i_shift,
  input  logic             i_clear_status,
  output logic [OUT_W-1:0] o_tdata,
  output logic             o_tuser,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             i_tready,
  output logic             o_overflow,
  output logic [15:0]      o_drop_count
);

  localparam int BW = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam logic signed [S:0] MAX_Q = {{(S-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [S:0] MIN_Q = {{(S-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic             s1_valid_q, s2_valid_q;
  logic [S-1:0]     s1_sum_q;
  logic [5:0]       s1_shift_q;
  dp_result_t       s2_res_q, res_d, wr_data, head;
  logic signed [S:0] sum_ext, rnd, rounded, quot;
  logic [BW-1:0]    batch_q;
  logic             fifo_full, fifo_empty, pop, wr_ok, drop;
  logic             overflow_q;
  logic [15:0]      drop_cnt_q;

  // Quantization runs one bit wider than the sum so the rounding add cannot wrap.
  always_comb begin
    sum_ext = {s1_sum_q[S-1], s1_sum_q};
    rnd     = '0;
    if (s1_shift_q != 6'd0) rnd = (S+1)'(1) << (s1_shift_q - 6'd1);
    rounded = sum_ext + rnd;
    quot    = rounded >>> s1_shift_q;
    res_d   = '0;
    if (quot > MAX_Q) begin
      res_d.data = MAX_Q[RESULT_W-1:0];
      res_d.sat  = 1'b1;
    end else if (quot < MIN_Q) begin
      res_d.data = MIN_Q[RESULT_W-1:0];
      res_d.sat  = 1'b1;
    end else begin
      res_d.data = quot[RESULT_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_shift_q <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      s1_valid_q <= i_valid;
      s2_valid_q <= s1_valid_q;
      if (i_valid) begin
        s1_sum_q   <= i_sum;
        s1_shift_q <= clamp_shift(i_shift, S);
      end
      if (s1_valid_q) s2_res_q <= res_d;
    end
  end

  assign pop   = o_tvalid && i_tready;
  assign wr_ok = s2_valid_q && (!fifo_full || pop);
  assign drop  = s2_valid_q && fifo_full && !pop;

  always_comb begin
    wr_data      = s2_res_q;
    wr_data.last = (batch_q == BW'(BATCH - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      batch_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (wr_ok) batch_q <= wr_data.last ? '0 : batch_q + 1'b1;
      // A drop in the same cycle as a clear must still be reported.
      if (drop) begin
        overflow_q <= 1'b1;
        if (i_clear_status)            drop_cnt_q <= 16'd1;
        else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end else if (i_clear_status) begin
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end
    end
  end

  dot_product_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (wr_ok),
    .i_wdata (wr_data),
    .i_pop   (pop),
    .o_rdata (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_tvalid     = !fifo_empty;
  assign o_tdata      = head.data[OUT_W-1:0];
  assign o_tuser      = head.sat;
  assign o_tlast      = head.last;
  assign o_overflow   = overflow_q;
  assign o_drop_count = drop_cnt_q;

endmodule
